// File: rtl/program_loader.sv
// Program RAM (256 x 8) filled by a framed byte-stream loader, read by the processor
// through a registered strobe port; cpuRun is granted only after a checksum-clean frame.
module program_loader (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] rxData,
  input  logic       rxValid,
  output logic       rxReady,
  input  logic [7:0] cpuAddr,
  input  logic       cpuStrobe,
  output logic [7:0] cpuDataRead,
  output logic       cpuRun,
  output logic       loadError
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    LEN    = 3'd2,
    DATA   = 3'd3,
    CHECK  = 3'd4,
    VERIFY = 3'd5
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic        accept_s;
  logic        mem_we_s;
  logic        ready_r;
  logic [7:0]  write_addr_r;
  logic [7:0]  sum_r;
  logic [8:0]  count_r;
  logic        match_r;
  logic        run_r;
  logic        error_r;
  logic [7:0]  read_data_r;
  logic [7:0]  mem_r [0:255];

  // running 8-bit checksum accumulation
  function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
    chk_add = acc + b;
  endfunction

  // ready_r is registered from the next state; resetN masks it while reset is held
  assign rxReady     = resetN & ready_r;
  assign accept_s    = rxValid & rxReady;
  assign cpuDataRead = read_data_r;
  assign cpuRun      = run_r;
  assign loadError   = error_r;

  // next-state and RAM write-enable decode
  always_comb begin
    next_state_s = state_r;
    mem_we_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s && (rxData == SYNC_BYTE)) begin
          next_state_s = ADDR;
        end else begin
          next_state_s = IDLE;
        end
      end
      ADDR: begin
        if (accept_s) begin
          next_state_s = LEN;
        end else begin
          next_state_s = ADDR;
        end
      end
      LEN: begin
        if (accept_s) begin
          next_state_s = DATA;
        end else begin
          next_state_s = LEN;
        end
      end
      DATA: begin
        if (accept_s) begin
          mem_we_s = 1'b1;
          if (count_r == 9'd1) begin
            next_state_s = CHECK;
          end else begin
            next_state_s = DATA;
          end
        end else begin
          next_state_s = DATA;
        end
      end
      CHECK: begin
        if (accept_s) begin
          next_state_s = VERIFY;
        end else begin
          next_state_s = CHECK;
        end
      end
      VERIFY: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // state register and byte-ready flag
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_r <= IDLE;
      ready_r <= 1'b1;
    end else begin
      state_r <= next_state_s;
      ready_r <= (next_state_s != VERIFY);
    end
  end

  // frame datapath: address pointer, byte count, checksum and run/error flags
  always_ff @(posedge clk) begin
    if (!resetN) begin
      write_addr_r <= 8'h00;
      sum_r        <= 8'h00;
      count_r      <= 9'd0;
      match_r      <= 1'b0;
      run_r        <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // a sync byte holds the processor even if it is running (hot reload)
          if (accept_s && (rxData == SYNC_BYTE)) begin
            run_r   <= 1'b0;
            error_r <= 1'b0;
            sum_r   <= 8'h00;
          end
        end
        ADDR: begin
          if (accept_s) begin
            write_addr_r <= rxData;
            sum_r        <= chk_add(sum_r, rxData);
          end
        end
        LEN: begin
          if (accept_s) begin
            count_r <= (rxData == 8'h00) ? 9'd256 : {1'b0, rxData};
            sum_r   <= chk_add(sum_r, rxData);
          end
        end
        DATA: begin
          if (accept_s) begin
            write_addr_r <= write_addr_r + 8'd1;
            sum_r        <= chk_add(sum_r, rxData);
            count_r      <= count_r - 9'd1;
          end
        end
        CHECK: begin
          if (accept_s) begin
            match_r <= (rxData == sum_r);
          end
        end
        VERIFY: begin
          run_r   <= match_r;
          error_r <= ~match_r;
        end
        default: begin
          run_r <= 1'b0;
        end
      endcase
    end
  end

  // RAM write port; bytes of an abandoned or failed frame are intentionally kept
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[write_addr_r] <= rxData;
    end
  end

  // processor read port: read-before-write against a same-edge loader write
  always_ff @(posedge clk) begin
    if (!resetN) begin
      read_data_r <= 8'h00;
    end else if (cpuStrobe) begin
      read_data_r <= mem_r[cpuAddr];
    end else begin
      read_data_r <= read_data_r;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: frames are driven byte by byte, a memory model
// tracks RAM, and expected read data is queued per strobe and compared on the data cycle.
module tb_program_loader;

  logic       clk;
  logic       resetN;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxReady;
  logic [7:0] cpuAddr;
  logic       cpuStrobe;
  logic [7:0] cpuDataRead;
  logic       cpuRun;
  logic       loadError;

  int n_checks;
  int n_fail;

  logic [7:0] model_mem [256];
  logic [7:0] payload_q [$];
  logic [7:0] exp_q [$];

  program_loader dut (
    .clk        (clk),
    .resetN     (resetN),
    .rxData     (rxData),
    .rxValid    (rxValid),
    .rxReady    (rxReady),
    .cpuAddr    (cpuAddr),
    .cpuStrobe  (cpuStrobe),
    .cpuDataRead(cpuDataRead),
    .cpuRun     (cpuRun),
    .loadError  (loadError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    rxData  = b;
    rxValid = 1'b1;
    while (!rxReady && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (t >= 20) begin
      n_fail++;
      $display("FAIL rx_handshake: got rxReady=%b expected 1 within 20 cycles", rxReady);
    end
    @(posedge clk);
    #1;
    rxValid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] start, input int n, input logic [7:0] corrupt,
                            input bit skip_sync, input bit hold_next);
    logic [7:0] sum;
    logic [7:0] a;
    logic [7:0] len_byte;
    logic       good;
    good     = (corrupt == 8'h00);
    len_byte = n[7:0];
    sum      = start + len_byte;
    a        = start;
    if (!skip_sync) send_byte(8'hA5);
    send_byte(start);
    send_byte(len_byte);
    for (int i = 0; i < n; i++) begin
      send_byte(payload_q[i]);
      model_mem[a] = payload_q[i];
      a   = a + 8'd1;
      sum = sum + payload_q[i];
    end
    send_byte(sum ^ corrupt);
    n_checks++;
    if (rxReady !== 1'b0) begin
      n_fail++;
      $display("FAIL verify_ready: got %b expected 0", rxReady);
    end
    if (hold_next) begin
      rxData  = 8'hA5;
      rxValid = 1'b1;
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (cpuRun !== good) begin
      n_fail++;
      $display("FAIL frame_run: got %b expected %b", cpuRun, good);
    end
    n_checks++;
    if (loadError !== !good) begin
      n_fail++;
      $display("FAIL frame_error: got %b expected %b", loadError, !good);
    end
    n_checks++;
    if (rxReady !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_verify: got %b expected 1", rxReady);
    end
    if (hold_next) begin
      @(posedge clk);
      #1;
      rxValid = 1'b0;
      n_checks++;
      if (cpuRun !== 1'b0) begin
        n_fail++;
        $display("FAIL reload_drop: got %b expected 0", cpuRun);
      end
    end
  endtask

  task automatic cpu_read(input logic [7:0] addr);
    logic [7:0] e;
    @(negedge clk);
    cpuAddr   = addr;
    cpuStrobe = 1'b1;
    exp_q.push_back(model_mem[addr]);
    @(posedge clk);
    #1;
    cpuStrobe = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (cpuDataRead !== e) begin
      n_fail++;
      $display("FAIL read_%h: got %h expected %h", addr, cpuDataRead, e);
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (rxReady !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", rxReady); end
    @(posedge clk);
    #1;
    n_checks++;
    if (cpuRun !== 1'b0) begin n_fail++; $display("FAIL reset_run: got %b expected 0", cpuRun); end
    n_checks++;
    if (loadError !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", loadError); end
    n_checks++;
    if (cpuDataRead !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", cpuDataRead); end
    @(negedge clk);
    resetN = 1'b1;
    #1;
    n_checks++;
    if (rxReady !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b expected 1", rxReady); end
  endtask

  task automatic test_good_load();
    payload_q = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h10, 3, 8'h00, 1'b0, 1'b0);
    cpu_read(8'h10);
    cpu_read(8'h11);
    cpu_read(8'h12);
    @(negedge clk);
    cpuAddr = 8'h10;
    @(posedge clk);
    #1;
    n_checks++;
    if (cpuDataRead !== 8'h33) begin n_fail++; $display("FAIL read_hold: got %h expected 33", cpuDataRead); end
  endtask

  task automatic test_bad_checksum();
    payload_q = '{8'h44, 8'h55, 8'h66};
    send_frame(8'h10, 3, 8'h01, 1'b0, 1'b0);
    cpu_read(8'h10);
    cpu_read(8'h11);
    cpu_read(8'h12);
    payload_q = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h10, 3, 8'h00, 1'b0, 1'b0);
    cpu_read(8'h11);
  endtask

  task automatic test_wrap();
    payload_q = '{8'h01, 8'h02, 8'h03};
    send_frame(8'hFE, 3, 8'h00, 1'b0, 1'b0);
    cpu_read(8'hFE);
    cpu_read(8'hFF);
    cpu_read(8'h00);
  endtask

  task automatic test_len_zero();
    payload_q.delete();
    for (int i = 0; i < 256; i++) payload_q.push_back(8'($urandom_range(0, 255)));
    send_frame(8'h80, 256, 8'h00, 1'b0, 1'b0);
    cpu_read(8'h80);
    cpu_read(8'hFF);
    cpu_read(8'h00);
    cpu_read(8'h7F);
  endtask

  task automatic test_noise_hold_reload();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    n_checks++;
    if (cpuRun !== 1'b1) begin n_fail++; $display("FAIL noise_run: got %b expected 1", cpuRun); end
    payload_q = '{8'hC1, 8'hC2};
    send_frame(8'h40, 2, 8'h00, 1'b0, 1'b1);
    payload_q = '{8'hD7};
    send_frame(8'h42, 1, 8'h00, 1'b1, 1'b0);
    cpu_read(8'h41);
    cpu_read(8'h42);
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'hA5);
    send_byte(8'h20);
    send_byte(8'h04);
    send_byte(8'hE1);
    model_mem[8'h20] = 8'hE1;
    send_byte(8'hE2);
    model_mem[8'h21] = 8'hE2;
    @(negedge clk);
    resetN = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_checks++;
    if (cpuRun !== 1'b0) begin n_fail++; $display("FAIL midreset_run: got %b expected 0", cpuRun); end
    @(negedge clk);
    resetN = 1'b1;
    payload_q = '{8'h5B, 8'h6C};
    send_frame(8'h30, 2, 8'h00, 1'b0, 1'b0);
    cpu_read(8'h20);
    cpu_read(8'h21);
    cpu_read(8'h31);
  endtask

  task automatic test_collision();
    logic [7:0] e;
    logic [7:0] sum;
    send_byte(8'hA5);
    send_byte(8'h10);
    send_byte(8'h01);
    @(negedge clk);
    rxData    = 8'h9C;
    rxValid   = 1'b1;
    cpuAddr   = 8'h10;
    cpuStrobe = 1'b1;
    exp_q.push_back(model_mem[8'h10]);
    @(posedge clk);
    #1;
    rxValid   = 1'b0;
    cpuStrobe = 1'b0;
    model_mem[8'h10] = 8'h9C;
    e = exp_q.pop_front();
    n_checks++;
    if (cpuDataRead !== e) begin n_fail++; $display("FAIL collision_old: got %h expected %h", cpuDataRead, e); end
    sum = 8'h10 + 8'h01 + 8'h9C;
    send_byte(sum);
    @(posedge clk);
    #1;
    n_checks++;
    if (cpuRun !== 1'b1) begin n_fail++; $display("FAIL collision_run: got %b expected 1", cpuRun); end
    cpu_read(8'h10);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    resetN    = 1'b0;
    rxData    = 8'h00;
    rxValid   = 1'b0;
    cpuAddr   = 8'h00;
    cpuStrobe = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_wrap();
    test_len_zero();
    test_noise_hold_reload();
    test_reset_mid_frame();
    test_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
